// File: rtl/learn_pkg.sv
// learn_pkg: state encoding, default widths and the saturating-increment
// helper shared by the learning_coach slice.
package learn_pkg;

  localparam int NOTE_W_DEF  = 4;
  localparam int IDX_W_DEF   = 5;
  localparam int DUR_W_DEF   = 26;
  localparam int SCORE_W_DEF = 8;
  localparam int TIMEOUT_DEF = 100_000_000;

  localparam int END_NOTE = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PROMPT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Saturates at 2^w-1 for a w-bit counter carried in 32 bits.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/learning_coach_key_event_detect.sv
// key_event_detect: rising-edge detector on the synchronised key level,
// emitting a one-cycle event together with the key code captured on it.
module key_event_detect #(
  parameter int NOTE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_key_pressed,
  input  logic [NOTE_W-1:0] i_pressed_key,
  output logic              o_key_event,
  output logic [NOTE_W-1:0] o_key_code
);

  logic              r_prev;
  logic              r_event;
  logic [NOTE_W-1:0] r_code;
  logic              w_rise;

  assign w_rise = i_key_pressed & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_event <= 1'b0;
      r_code  <= '0;
    end else begin
      r_prev  <= i_key_pressed;
      r_event <= w_rise;
      if (w_rise) begin
        r_code <= i_pressed_key;
      end
    end
  end

  assign o_key_event = r_event;
  assign o_key_code  = r_code;

endmodule

// File: rtl/learning_coach.sv
// learning_coach: guided song practice between keypad, song ROM and buzzer.
// Optional wait-for-key timeout is built only with LEARN_TIMEOUT_EN.
module learning_coach
  import learn_pkg::*;
#(
  parameter int NOTE_W      = NOTE_W_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int DUR_W       = DUR_W_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         song_select,
  input  logic [NOTE_W-1:0]  pressed_key,
  input  logic               key_pressed,
  output logic [2:0]         rom_song,
  output logic [IDX_W-1:0]   rom_index,
  input  logic [NOTE_W-1:0]  rom_note,
  input  logic [DUR_W-1:0]   rom_duration,
  output logic [NOTE_W-1:0]  note_to_play,
  output logic               play_note,
  output logic               note_buzzed,
  output logic               error_pulse,
  output logic [SCORE_W-1:0] hit_count,
  output logic [SCORE_W-1:0] miss_count,
  output logic               busy,
  output logic               done
);

  state_e             r_state;
  logic [2:0]         r_song;
  logic [IDX_W-1:0]   r_idx;
  logic [DUR_W-1:0]   r_dur;
  logic [SCORE_W-1:0] r_hit;
  logic [SCORE_W-1:0] r_miss;
  logic               r_err;

  logic               w_key_event;
  logic [NOTE_W-1:0]  w_key_code;
  logic               w_prompt;
  logic               w_wait;
  logic               w_end;
  logic [DUR_W-1:0]   w_hold;
  logic               w_last;
  logic               w_match;
  logic               w_idx_max;
  logic [SCORE_W-1:0] w_hit_inc;
  logic [SCORE_W-1:0] w_miss_inc;
  logic               w_timeout;

  key_event_detect #(
    .NOTE_W (NOTE_W)
  ) u_key (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_pressed (key_pressed),
    .i_pressed_key (pressed_key),
    .o_key_event   (w_key_event),
    .o_key_code    (w_key_code)
  );

  assign w_prompt  = (r_state == ST_PROMPT);
  assign w_wait    = (r_state == ST_WAIT);
  assign w_end     = (rom_note == NOTE_W'(END_NOTE));
  assign w_hold    = (rom_duration == '0) ? DUR_W'(1) : rom_duration;
  assign w_last    = (r_dur == w_hold - DUR_W'(1));
  assign w_match   = (w_key_code == rom_note);
  assign w_idx_max = (r_idx == '1);

  assign w_hit_inc  = SCORE_W'(sat_inc(32'(r_hit), SCORE_W));
  assign w_miss_inc = SCORE_W'(sat_inc(32'(r_miss), SCORE_W));

`ifdef LEARN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to;

  // Held at zero outside WAIT_KEY so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to <= '0;
    end else if (!w_wait) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + TO_W'(1);
    end
  end

  assign w_timeout = w_wait && (r_to == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_song  <= '0;
      r_idx   <= '0;
      r_dur   <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_dur <= '0;
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              r_song  <= song_select;
              r_idx   <= '0;
              r_hit   <= '0;
              r_miss  <= '0;
              r_state <= ST_PROMPT;
            end
          end
          ST_PROMPT: begin
            if (w_end) begin
              r_state <= ST_DONE;
            end else if (w_last) begin
              r_state <= ST_WAIT;
            end else begin
              r_dur <= r_dur + DUR_W'(1);
            end
          end
          ST_WAIT: begin
            if (w_key_event) begin
              if (w_match) begin
                r_hit <= w_hit_inc;
                if (w_idx_max) begin
                  r_state <= ST_DONE;
                end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_state <= ST_PROMPT;
                end
              end else begin
                r_err   <= 1'b1;
                r_miss  <= w_miss_inc;
                r_state <= ST_PROMPT;
              end
            end else if (w_timeout) begin
              r_err   <= 1'b1;
              r_miss  <= w_miss_inc;
              r_state <= ST_PROMPT;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign play_note    = w_prompt && !w_end;
  assign note_to_play = play_note ? rom_note : '0;
  assign note_buzzed  = play_note && (r_dur == '0);
  assign error_pulse  = r_err;
  assign rom_song     = r_song;
  assign rom_index    = r_idx;
  assign hit_count    = r_hit;
  assign miss_count   = r_miss;
  assign busy         = w_prompt || w_wait;
  assign done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_learning_coach.sv
// tb_learning_coach: randomized songs and key presses against a
// note-by-note practice model of the learning coach.
module tb_learning_coach;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  song_select = '0;
  logic [3:0]  pressed_key = '0;
  logic        key_pressed = 1'b0;
  logic [2:0]  rom_song;
  logic [4:0]  rom_index;
  logic [3:0]  rom_note;
  logic [25:0] rom_duration;
  logic [3:0]  note_to_play;
  logic        play_note;
  logic        note_buzzed;
  logic        error_pulse;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;
  logic        busy;
  logic        done;

  logic [3:0]  song_n [0:7][0:31];
  logic [25:0] song_d [0:7][0:31];

  int vectors = 0;
  int miscompares = 0;
  int m_hit, m_miss, m_idx;
  bit m_done;

  always #5 clk = ~clk;

  assign rom_note     = song_n[rom_song][rom_index];
  assign rom_duration = song_d[rom_song][rom_index];

  learning_coach #(
    .TIMEOUT_CYC (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .song_select  (song_select),
    .pressed_key  (pressed_key),
    .key_pressed  (key_pressed),
    .rom_song     (rom_song),
    .rom_index    (rom_index),
    .rom_note     (rom_note),
    .rom_duration (rom_duration),
    .note_to_play (note_to_play),
    .play_note    (play_note),
    .note_buzzed  (note_buzzed),
    .error_pulse  (error_pulse),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [3:0] wrong_key(input logic [3:0] k);
    logic [3:0] w;
    w = 4'($urandom_range(0, 15));
    if (w == k) w = k + 4'd1;
    return w;
  endfunction

  function automatic int sat8(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic set_song(input int s, input int len, input int maxdur);
    for (int i = 0; i < 32; i++) begin
      song_n[s][i] = (i < len) ? 4'($urandom_range(1, 15)) : 4'd0;
      song_d[s][i] = 26'($urandom_range(0, maxdur));
    end
  endtask

  task automatic clean_idle();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic start_song(input int s);
    @(negedge clk);
    song_select = 3'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    song_select = 3'($urandom_range(0, 7));
    m_hit = 0;
    m_miss = 0;
    m_idx = 0;
    m_done = 1'b0;
  endtask

  task automatic check_prompt(input int s);
    int n, cnt, want;
    n = 0;
    while (note_buzzed !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (note_buzzed !== 1'b1) begin
      $display("FAIL prompt_wait: note_buzzed=%b expected 1 idx=%0d", note_buzzed, m_idx);
      miscompares++;
      return;
    end
    vectors++;
    if (note_to_play !== song_n[s][m_idx] || rom_index !== 5'(m_idx)) begin
      $display("FAIL prompt_note: note=%0d idx=%0d expected note=%0d idx=%0d",
               note_to_play, rom_index, song_n[s][m_idx], m_idx);
      miscompares++;
    end
    want = (song_d[s][m_idx] == 0) ? 1 : int'(song_d[s][m_idx]);
    cnt = 0;
    while (play_note === 1'b1 && cnt < 100) begin
      if (cnt == 1) begin
        vectors++;
        if (error_pulse !== 1'b0 || note_buzzed !== 1'b0) begin
          $display("FAIL pulse_width: error_pulse=%b note_buzzed=%b expected 0 0",
                   error_pulse, note_buzzed);
          miscompares++;
        end
      end
      cnt++;
      @(negedge clk);
    end
    vectors++;
    if (cnt != want) begin
      $display("FAIL play_len: %0d cycles expected %0d", cnt, want);
      miscompares++;
    end
  endtask

  task automatic press(input int s, input logic [3:0] k);
    logic [3:0] want;
    logic exp_err, exp_buzz;
    want = song_n[s][m_idx];
    pressed_key = k;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    exp_err = (k != want);
    exp_buzz = 1'b1;
    if (exp_err) begin
      m_miss = sat8(m_miss);
    end else begin
      m_hit = sat8(m_hit);
      if (m_idx == 31) begin
        m_done = 1'b1;
        exp_buzz = 1'b0;
      end else begin
        m_idx++;
        exp_buzz = (song_n[s][m_idx] != 4'd0);
      end
    end
    vectors++;
    if ({error_pulse, note_buzzed} !== {exp_err, exp_buzz}) begin
      $display("FAIL key_resp: err=%b buzz=%b expected err=%b buzz=%b",
               error_pulse, note_buzzed, exp_err, exp_buzz);
      miscompares++;
    end
    vectors++;
    if (hit_count !== 8'(m_hit) || miss_count !== 8'(m_miss) || rom_index !== 5'(m_idx)) begin
      $display("FAIL key_counts: hit=%0d miss=%0d idx=%0d expected %0d %0d %0d",
               hit_count, miss_count, rom_index, m_hit, m_miss, m_idx);
      miscompares++;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || play_note !== 1'b0) begin
      $display("FAIL done_state: done=%b busy=%b play=%b expected 1 0 0", done, busy, play_note);
      miscompares++;
    end
    vectors++;
    if (hit_count !== 8'(m_hit) || miss_count !== 8'(m_miss) || rom_index !== 5'(m_idx)) begin
      $display("FAIL done_counts: hit=%0d miss=%0d idx=%0d expected %0d %0d %0d",
               hit_count, miss_count, rom_index, m_hit, m_miss, m_idx);
      miscompares++;
    end
  endtask

  task automatic run_song(input int s, input int wrong_pct);
    int guard;
    logic [3:0] k;
    start_song(s);
    guard = 0;
    while (!m_done && song_n[s][m_idx] != 4'd0 && guard < 200) begin
      check_prompt(s);
      k = song_n[s][m_idx];
      if ($urandom_range(0, 99) < wrong_pct) k = wrong_key(k);
      press(s, k);
      guard++;
    end
    wait_done();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({rom_song, rom_index, note_to_play, play_note, note_buzzed, error_pulse,
         hit_count, miss_count, busy, done} !== 33'd0) begin
      $display("FAIL reset_outputs: busy=%b done=%b hit=%0d idx=%0d expected all 0",
               busy, done, hit_count, rom_index);
      miscompares++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || play_note !== 1'b0) begin
      $display("FAIL reset_idle: busy=%b done=%b play=%b expected 0 0 0", busy, done, play_note);
      miscompares++;
    end
  endtask

  task automatic test_basic_song();
    clean_idle();
    start_song(0);
    check_prompt(0);
    press(0, 4'd3);
    check_prompt(0);
    press(0, 4'd5);
    wait_done();
  endtask

  task automatic test_wrong_key();
    clean_idle();
    start_song(1);
    check_prompt(1);
    press(1, 4'd7);
    check_prompt(1);
    press(1, 4'd3);
    check_prompt(1);
    start = 1'b1;
    song_select = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || hit_count !== 8'd1 || miss_count !== 8'd1 ||
        rom_song !== 3'd1 || rom_index !== 5'd1) begin
      $display("FAIL start_busy: busy=%b hit=%0d miss=%0d song=%0d idx=%0d expected 1 1 1 1 1",
               busy, hit_count, miss_count, rom_song, rom_index);
      miscompares++;
    end
    press(1, 4'd9);
    wait_done();
  endtask

  task automatic test_held_key();
    clean_idle();
    pressed_key = 4'd3;
    key_pressed = 1'b1;
    start_song(2);
    check_prompt(2);
    repeat (6) @(negedge clk);
    vectors++;
    if (hit_count !== 8'd0 || busy !== 1'b1 || play_note !== 1'b0 || rom_index !== 5'd0) begin
      $display("FAIL held_key: hit=%0d busy=%b play=%b idx=%0d expected 0 1 0 0",
               hit_count, busy, play_note, rom_index);
      miscompares++;
    end
    key_pressed = 1'b0;
    @(negedge clk);
    press(2, 4'd3);
    wait_done();
  endtask

  task automatic test_async_reset();
    clean_idle();
    start_song(0);
    check_prompt(0);
    press(0, 4'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rom_song, rom_index, note_to_play, play_note, note_buzzed, error_pulse,
         hit_count, miss_count, busy, done} !== 33'd0) begin
      $display("FAIL async_reset: play=%b hit=%0d idx=%0d busy=%b expected all 0",
               play_note, hit_count, rom_index, busy);
      miscompares++;
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hit_count !== 8'd0 || play_note !== 1'b0) begin
      $display("FAIL reset_release: busy=%b done=%b hit=%0d play=%b expected 0 0 0 0",
               busy, done, hit_count, play_note);
      miscompares++;
    end
  endtask

  task automatic test_abort_key();
    clean_idle();
    start_song(0);
    check_prompt(0);
    press(0, 4'd3);
    check_prompt(0);
    pressed_key = 4'd5;
    key_pressed = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    key_pressed = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || hit_count !== 8'd1 || play_note !== 1'b0) begin
        $display("FAIL abort_key: busy=%b done=%b hit=%0d play=%b expected 0 0 1 0",
                 busy, done, hit_count, play_note);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int n;
    int seen;
    clean_idle();
    start_song(0);
    check_prompt(0);
`ifdef LEARN_TIMEOUT_EN
    n = 0;
    while (note_buzzed !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 10 || error_pulse !== 1'b1 || miss_count !== 8'd1 || rom_index !== 5'd0) begin
      $display("FAIL timeout: after %0d cycles err=%b miss=%0d idx=%0d expected 10 1 1 0",
               n, error_pulse, miss_count, rom_index);
      miscompares++;
    end
`else
    seen = 0;
    for (n = 0; n < 1000; n++) begin
      if (note_buzzed === 1'b1 || error_pulse === 1'b1) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen != 0 || busy !== 1'b1 || play_note !== 1'b0 || miss_count !== 8'd0) begin
      $display("FAIL no_timeout: events=%0d busy=%b play=%b miss=%0d expected 0 1 0 0",
               seen, busy, play_note, miss_count);
      miscompares++;
    end
`endif
    clean_idle();
  endtask

  task automatic test_saturation();
    clean_idle();
    set_song(6, 1, 0);
    start_song(6);
    for (int i = 0; i < 260; i++) begin
      check_prompt(6);
      press(6, wrong_key(song_n[6][0]));
    end
    check_prompt(6);
    press(6, song_n[6][0]);
    wait_done();
  endtask

  task automatic test_random_songs();
    for (int r = 0; r < 8; r++) begin
      set_song(3 + (r % 3), $urandom_range(0, 10), 5);
      run_song(3 + (r % 3), 30);
    end
    set_song(7, 32, 2);
    run_song(7, 20);
    run_song(7, 0);
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 32; i++) begin
        song_n[s][i] = 4'd0;
        song_d[s][i] = 26'd0;
      end
    end
    song_n[0][0] = 4'd3; song_d[0][0] = 26'd4;
    song_n[0][1] = 4'd5; song_d[0][1] = 26'd4;
    song_n[1][0] = 4'd3; song_d[1][0] = 26'd2;
    song_n[1][1] = 4'd9; song_d[1][1] = 26'd3;
    song_n[2][0] = 4'd3; song_d[2][0] = 26'd4;

    test_reset();
    test_basic_song();
    test_wrong_key();
    test_held_key();
    test_async_reset();
    test_abort_key();
    test_timeout();
    test_saturation();
    test_random_songs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
